// File: rtl/fetch_queue.sv
// fetch_queue: circular instruction queue between fetch and decode.
// Each entry holds one 64-bit {pc, instr} pair.
// Fetch can push one or two entries per cycle. Decode can pop one or two
// from the head, strictly in order.
// Optional feature macro: FETCHQ_PERF_EN builds the queue-empty (starvation)
// cycle counter. When it is undefined, perf_starve_cnt is tied to zero.
`timescale 1ns/1ps
module fetch_queue #(
   parameter int DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic        in_b_valid,
   input  logic [31:0] in_pc,
   input  logic [31:0] in_instr_a,
   input  logic [31:0] in_instr_b,
   output logic        in_ready,
   output logic        out_a_valid,
   output logic        out_b_valid,
   output logic [31:0] out_a_instr,
   output logic [31:0] out_a_pc,
   output logic [31:0] out_b_instr,
   output logic [31:0] out_b_pc,
   input  logic        id_take_a,
   input  logic        id_take_b,
   input  logic        flush,
   output logic [31:0] perf_starve_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [CW-1:0] CNT_TWO   = CW'(2);
   localparam logic [AW-1:0] PTR_ONE   = AW'(1);

   logic [AW-1:0] head_q, head_d;
   logic [AW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;

   logic [63:0]   entry_mem [DEPTH];

   logic          push_en;
   logic [1:0]    push_n;
   logic          take_a_ok;
   logic          take_b_ok;
   logic [1:0]    pop_n;
   logic [AW-1:0] wr_b_idx;
   logic [AW-1:0] rd_b_idx;

   // Handshake and take qualification. Every term depends only on registered
   // count and the inputs, so in_ready never sees a path from take or flush.
   always_comb begin
      in_ready  = (count_q <= READY_MAX);
      push_en   = in_valid && in_ready && !flush;
      push_n    = 2'd0;
      if (push_en) begin
         push_n = in_b_valid ? 2'd2 : 2'd1;
      end
      take_a_ok = id_take_a && (count_q >= CNT_ONE);
      take_b_ok = take_a_ok && id_take_b && (count_q >= CNT_TWO);
      pop_n     = {1'b0, take_a_ok} + {1'b0, take_b_ok};
      wr_b_idx  = tail_q + PTR_ONE;
      rd_b_idx  = head_q + PTR_ONE;
   end

   // Next pointer/count values. Flush overrides any push or pop in the same
   // cycle. Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         head_d  = head_q + AW'(pop_n);
         tail_d  = tail_q + AW'(push_n);
         count_d = count_q + CW'(push_n) - CW'(pop_n);
      end
   end

   // Pointer and occupancy registers. Reset takes priority over flush.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry storage. It is not reset, because entries outside [head, head+count) are never observed as valid.
   always_ff @(posedge clk) begin
      if (push_en) begin
         entry_mem[tail_q] <= {in_pc, in_instr_a};
         if (in_b_valid) begin
            entry_mem[wr_b_idx] <= {in_pc + 32'd4, in_instr_b};
         end
      end
   end

   // Head and head+1 are presented combinationally to decode.
   always_comb begin
      out_a_valid = (count_q >= CNT_ONE);
      out_b_valid = (count_q >= CNT_TWO);
      {out_a_pc, out_a_instr} = entry_mem[head_q];
      {out_b_pc, out_b_instr} = entry_mem[rd_b_idx];
   end

`ifdef FETCHQ_PERF_EN
   logic [31:0] starve_cnt_q, starve_cnt_d;

   // Starvation counter. It counts each cycle the queue is empty and saturates at all-ones.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if ((count_q == '0) && (starve_cnt_q != 32'hFFFF_FFFF)) begin
         starve_cnt_d = starve_cnt_q + 32'd1;
      end
   end

   // Starvation counter register, cleared only by reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         starve_cnt_q <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end

   assign perf_starve_cnt = starve_cnt_q;
`else
   assign perf_starve_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: self-checking bench for fetch_queue.
// The reference model is a plain queue of {pc, instr} entries plus an
// empty-cycle counter.
// FETCHQ_PERF_EN selects the expected starvation counter behaviour.
`timescale 1ns/1ps
module tb_fetch_queue;

   localparam int DEPTH = 8;

`ifdef FETCHQ_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_b_valid = 1'b0;
   logic [31:0] in_pc = '0;
   logic [31:0] in_instr_a = '0;
   logic [31:0] in_instr_b = '0;
   logic        in_ready;
   logic        out_a_valid;
   logic        out_b_valid;
   logic [31:0] out_a_instr;
   logic [31:0] out_a_pc;
   logic [31:0] out_b_instr;
   logic [31:0] out_b_pc;
   logic        id_take_a = 1'b0;
   logic        id_take_b = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] perf_starve_cnt;

   int          compared = 0;
   int          mismatched = 0;
   logic [63:0] mq[$];
   logic [31:0] starve_m = '0;

   fetch_queue #(.DEPTH(DEPTH)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .in_valid        (in_valid),
      .in_b_valid      (in_b_valid),
      .in_pc           (in_pc),
      .in_instr_a      (in_instr_a),
      .in_instr_b      (in_instr_b),
      .in_ready        (in_ready),
      .out_a_valid     (out_a_valid),
      .out_b_valid     (out_b_valid),
      .out_a_instr     (out_a_instr),
      .out_a_pc        (out_a_pc),
      .out_b_instr     (out_b_instr),
      .out_b_pc        (out_b_pc),
      .id_take_a       (id_take_a),
      .id_take_b       (id_take_b),
      .flush           (flush),
      .perf_starve_cnt (perf_starve_cnt)
   );

   // Free-running clock, 10 ns period.
   always #5 clk = ~clk;

   task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput();
      int n;
      n = mq.size();
      checkValue("in_ready", {31'd0, in_ready}, (n <= DEPTH - 2) ? 32'd1 : 32'd0);
      checkValue("a_valid", {31'd0, out_a_valid}, (n >= 1) ? 32'd1 : 32'd0);
      checkValue("b_valid", {31'd0, out_b_valid}, (n >= 2) ? 32'd1 : 32'd0);
      checkValue("starve", perf_starve_cnt, starve_m);
      if (n >= 1) begin
         checkValue("a_pc", out_a_pc, mq[0][63:32]);
         checkValue("a_instr", out_a_instr, mq[0][31:0]);
      end
      if (n >= 2) begin
         checkValue("b_pc", out_b_pc, mq[1][63:32]);
         checkValue("b_instr", out_b_instr, mq[1][31:0]);
      end
   endtask

   task automatic doReset();
      @(negedge clk);
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_b_valid = 1'b0;
      id_take_a  = 1'b0;
      id_take_b  = 1'b0;
      flush      = 1'b0;
      @(posedge clk);
      mq.delete();
      starve_m = '0;
      #1;
      checkOutput();
   endtask

   task automatic applyStimulus(input bit inv, input bit bv, input logic [31:0] pc,
                                input logic [31:0] a, input logic [31:0] b,
                                input bit ta, input bit tb, input bit fl);
      int n;
      bit push;
      bit ta_ok;
      bit tb_ok;
      @(negedge clk);
      rst_n      = 1'b1;
      in_valid   = inv;
      in_b_valid = bv;
      in_pc      = pc;
      in_instr_a = a;
      in_instr_b = b;
      id_take_a  = ta;
      id_take_b  = tb;
      flush      = fl;
      @(posedge clk);
      n = mq.size();
      if (PERF && n == 0 && starve_m != 32'hFFFF_FFFF) begin
         starve_m = starve_m + 32'd1;
      end
      push  = inv && (n <= DEPTH - 2) && !fl;
      ta_ok = ta && (n >= 1);
      tb_ok = ta_ok && tb && (n >= 2);
      if (fl) begin
         mq.delete();
      end else begin
         if (ta_ok) void'(mq.pop_front());
         if (tb_ok) void'(mq.pop_front());
         if (push) begin
            mq.push_back({pc, a});
            if (bv) mq.push_back({pc + 32'd4, b});
         end
      end
      #1;
      checkOutput();
   endtask

   task automatic idle();
      applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic push2(input logic [31:0] pc);
      applyStimulus(1'b1, 1'b1, pc, pc ^ 32'hA5A5_0000, pc ^ 32'h5A5A_0000, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic push1(input logic [31:0] pc);
      applyStimulus(1'b1, 1'b0, pc, pc ^ 32'hA5A5_0000, 32'd0, 1'b0, 1'b0, 1'b0);
   endtask

   // Directed scenarios first, then a randomized run against the queue model.
   initial begin
      doReset();
      checkValue("rst_ready", {31'd0, in_ready}, 32'd1);
      checkValue("rst_a_valid", {31'd0, out_a_valid}, 32'd0);

      for (int i = 0; i < 10; i++) idle();
      checkValue("starve10", perf_starve_cnt, PERF ? 32'd10 : 32'd0);

      applyStimulus(1'b1, 1'b1, 32'h100, 32'h0050_0093, 32'h00A0_0113, 1'b0, 1'b0, 1'b0);
      checkValue("p035_a_pc", out_a_pc, 32'h100);
      checkValue("p035_b_pc", out_b_pc, 32'h104);
      checkValue("p035_a_instr", out_a_instr, 32'h0050_0093);
      checkValue("p035_b_instr", out_b_instr, 32'h00A0_0113);
      checkValue("p035_b_valid", {31'd0, out_b_valid}, 32'd1);

      push2(32'h200);
      push2(32'h300);
      push1(32'h400);
      checkValue("full_ready", {31'd0, in_ready}, 32'd0);
      push2(32'h500);
      applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
      checkValue("after_take_ready", {31'd0, in_ready}, 32'd1);
      checkValue("after_take_a_pc", out_a_pc, 32'h104);

      doReset();
      push2(32'h1000);
      push1(32'h2000);
      applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
      checkValue("holdb_a_pc", out_a_pc, 32'h1000);
      applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
      checkValue("takeab_a_pc", out_a_pc, 32'h2000);
      checkValue("takeab_b_valid", {31'd0, out_b_valid}, 32'd0);

      doReset();
      push2(32'h3000);
      push2(32'h3008);
      push2(32'h3010);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
      end
      push2(32'h4000);
      applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
      push1(32'h5000);
      applyStimulus(1'b1, 1'b1, 32'h6000, 32'h6000_0001, 32'h6000_0002, 1'b1, 1'b1, 1'b0);
      checkValue("wrap_a_pc", out_a_pc, 32'h6000);
      checkValue("wrap_b_pc", out_b_pc, 32'h6004);

      doReset();
      push2(32'h7000);
      push2(32'h7008);
      push1(32'h7010);
      applyStimulus(1'b1, 1'b1, 32'h8000, 32'd1, 32'd2, 1'b1, 1'b0, 1'b1);
      checkValue("flush_a_valid", {31'd0, out_a_valid}, 32'd0);
      checkValue("flush_ready", {31'd0, in_ready}, 32'd1);

      for (int i = 0; i < 400; i++) begin
         applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
                       $urandom & 32'hFFFF_FFFC, $urandom, $urandom,
                       $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
                       $urandom_range(0, 19) == 0);
         if (i == 200) doReset();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
